sram_1rw_port_arbiter: RTL and testbench
========================================

Name: sram_1rw_port_arbiter

Overview:
- Front-end controller feeding a 512x80 single-port SRAM macro: 9-bit address, eight 10-bit write lanes, one-cycle registered read.
- Arbitrates a masked-write request channel and a read request channel onto the one RW port, with write priority and a read anti-starvation counter.
- Captures read data into a 2-entry response queue with valid/ready backpressure, so consumers never lose the SRAM's one-cycle read data.

Parameters:
- ADDR_W, 9, SRAM address width
- DATA_W, 80, SRAM data width
- MASK_W, 8, write-mask lanes; each lane is DATA_W/MASK_W = 10 bits
- STARVE_MAX, 4, consecutive write grants allowed while an eligible read waits; range 1..15

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- w_valid  in  1  write request valid
- w_ready  out  1  write accepted this cycle
- w_addr  in  ADDR_W  write address
- w_mask  in  MASK_W  per-lane write enable
- w_data  in  DATA_W  write data
- r_valid  in  1  read request valid
- r_ready  out  1  read accepted this cycle
- r_addr  in  ADDR_W  read address
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer accepts resp_data
- resp_data  out  DATA_W  read data, in request order
- RW0_en  out  1  SRAM enable
- RW0_wmode  out  1  1 = write, 0 = read
- RW0_addr  out  ADDR_W  SRAM address
- RW0_wmask  out  MASK_W  SRAM write mask
- RW0_wdata  out  DATA_W  SRAM write data
- RW0_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - queue empty, resp_valid=0, resp_data=0.
  - inflight=0, starve_cnt=0.
  - Any in-flight read is discarded; no response is produced for it.
- Read eligibility:
  - read_ok = (occupancy + inflight - pop) < 2, where pop = resp_valid & resp_ready.
  - This lookahead keeps full back-to-back read throughput when resp_ready=1.
- Arbitration, all combinational in the same cycle:
  - force_rd = (starve_cnt == STARVE_MAX).
  - grant_r = r_valid & read_ok & (~w_valid | force_rd).
  - grant_w = w_valid & ~grant_r.
  - w_ready = grant_w; r_ready = grant_r. At most one grant per cycle.
- SRAM drive:
  - RW0_en = grant_w | grant_r; RW0_wmode = grant_w.
  - RW0_addr = grant_w ? w_addr : r_addr.
  - RW0_wmask = w_mask, RW0_wdata = w_data; both don't-care when wmode=0.
  - A write with w_mask=0 is still granted and consumes a slot.
- Starvation counter (4-bit, saturating):
  - increments when grant_w & r_valid & read_ok; never exceeds STARVE_MAX.
  - clears on grant_r, or when r_valid=0 or read_ok=0.
- Read pipeline:
  - inflight register <= grant_r.
  - When inflight=1, RW0_rdata is pushed into the queue at that edge.
  - Grant-to-resp_valid latency is 2 cycles.
- Response queue:
  - 2-entry FIFO; resp_data is the head entry.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Push while full cannot occur; an assertion flags it.
- Ordering and hazards:
  - Responses are strictly in grant order.
  - A write at cycle t followed by a read of the same address at t+1 returns the new data. The SRAM commits at the edge, so no forwarding is required.
- Deadlock freedom: writes progress regardless of response backpressure; reads stall only on queue credit.

Test Plan:
- Reset, then write addr 0x005, mask 0xFF, data 0x0123456789ABCDEF0011; read 0x005 next cycle -> resp_valid 2 cycles after r_ready, resp_data = written value.
- Partial write: mask 0x01, data 0x3FF at addr 0x1FF over prior all-zero -> read returns 0x0000...03FF; lanes 1-7 unchanged.
- w_valid and r_valid both held high, STARVE_MAX=4 -> grant pattern W,W,W,W,R repeating; starve_cnt never exceeds 4.
- resp_ready=0, issue 4 reads -> exactly 2 granted, then r_ready=0 while writes still granted; raise resp_ready -> remaining reads flow, responses in order.
- Streaming reads of addr 0..7 with resp_ready=1 -> r_ready high 8 consecutive cycles; resp_valid high 8 consecutive cycles starting 2 cycles later.
- Assert reset_n=0 one cycle after a read grant -> no response emitted, queue empty, all outputs at reset values; first post-reset read returns correct data.

Source files
------------

// File: rtl/sram_1rw_port_arbiter.sv
// Front end for a 512x80 single-port SRAM: arbitrates masked writes and reads onto
// the one RW port and buffers the one-cycle read data in a 2-entry response queue.
module sram_1rw_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 80,
  parameter int MASK_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int CNT_W = 4;

  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] entry_q [2];
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic              pop, push, read_ok, force_rd, grant_r, grant_w;
  logic [2:0]        credit_use;

  assign pop  = resp_valid & resp_ready;
  assign push = inflight_q;

  // Credit lookahead: a slot freed by this cycle's pop is reusable immediately.
  assign credit_use = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign read_ok    = (credit_use < 3'd2);

  assign force_rd = (starve_q == CNT_W'(STARVE_MAX));
  assign grant_r  = r_valid & read_ok & (~w_valid | force_rd);
  assign grant_w  = w_valid & ~grant_r;

  assign w_ready   = grant_w;
  assign r_ready   = grant_r;
  assign RW0_en    = grant_w | grant_r;
  assign RW0_wmode = grant_w;
  assign RW0_addr  = grant_w ? w_addr : r_addr;
  assign RW0_wmask = w_mask;
  assign RW0_wdata = w_data;

  assign resp_valid = (count_q != 2'd0);
  assign resp_data  = entry_q[rd_ptr_q];

  assign inflight_d = grant_r;
  assign count_d    = count_q + {1'b0, push} - {1'b0, pop};

  // Counts write wins only while a read could actually have gone; anything else resets it.
  always_comb begin
    starve_d = '0;
    if (grant_w && r_valid && read_ok) begin
      if (starve_q < CNT_W'(STARVE_MAX)) starve_d = starve_q + 1'b1;
      else                               starve_d = starve_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
      starve_q   <= '0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      starve_q   <= starve_d;
      if (push) begin
        entry_q[wr_ptr_q] <= RW0_rdata;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && count_q == 2'd2));

endmodule

// File: tb/tb_sram_1rw_port_arbiter.sv
// Randomized and directed bench for sram_1rw_port_arbiter with an SRAM device model
// and a transaction-level reference (shadow memory plus queue of expected responses).
module tb_sram_1rw_port_arbiter;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 80;
  localparam int MASK_W     = 8;
  localparam int STARVE_MAX = 4;
  localparam int LANE_W     = DATA_W / MASK_W;
  localparam int DEPTH      = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef struct { word_t data; int unsigned g; } rd_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr = '0;
  logic [MASK_W-1:0] w_mask = '0;
  word_t             w_data = '0;
  logic              r_valid = 1'b0;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  word_t             resp_data;
  logic              RW0_en, RW0_wmode;
  logic [ADDR_W-1:0] RW0_addr;
  logic [MASK_W-1:0] RW0_wmask;
  word_t             RW0_wdata, RW0_rdata;

  always #5 clock = ~clock;

  sram_1rw_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
                          .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset_n(reset_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  // SRAM macro model: masked write or registered read on an enabled edge.
  word_t sram_mem [0:DEPTH-1] = '{default: '0};
  word_t sram_rdata_q = '0;

  function automatic word_t merge_lanes(input word_t old, input logic [MASK_W-1:0] m,
                                        input word_t d);
    word_t r = old;
    for (int l = 0; l < MASK_W; l++)
      if (m[l]) r[l*LANE_W +: LANE_W] = d[l*LANE_W +: LANE_W];
    return r;
  endfunction

  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) sram_mem[RW0_addr] <= merge_lanes(sram_mem[RW0_addr], RW0_wmask, RW0_wdata);
      else           sram_rdata_q <= sram_mem[RW0_addr];
    end
  end
  assign RW0_rdata = sram_rdata_q;

  // Reference model state
  word_t       shadow [0:DEPTH-1] = '{default: '0};
  rd_t         pend[$];
  int unsigned cyc = 0;
  int          wcnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          last_rr, last_wr, last_rv;

  task automatic check_val(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic word_t expand_mask(input logic [MASK_W-1:0] m);
    word_t r = '0;
    for (int b = 0; b < DATA_W; b++) r[b] = m[b / LANE_W];
    return r;
  endfunction

  // One cycle: check outputs at the falling edge, advance the model, return at posedge+1.
  task automatic step();
    int vis, infl;
    bit pop, ok, frc, gr, gw, erv;
    word_t m;
    @(negedge clock);
    vis = 0; infl = 0;
    foreach (pend[i]) begin
      if (cyc >= pend[i].g + 2) vis++;
      else if (cyc == pend[i].g + 1) infl++;
    end
    erv = (pend.size() > 0) && (cyc >= pend[0].g + 2);
    pop = erv && resp_ready;
    ok  = (vis + infl - int'(pop)) < 2;
    frc = (wcnt == STARVE_MAX);
    gr  = r_valid && ok && (!w_valid || frc);
    gw  = w_valid && !gr;
    check_val("w_ready", word_t'(w_ready), word_t'(gw));
    check_val("r_ready", word_t'(r_ready), word_t'(gr));
    check_val("rw_en", word_t'(RW0_en), word_t'(gw || gr));
    if (gw || gr) begin
      check_val("rw_wmode", word_t'(RW0_wmode), word_t'(gw));
      check_val("rw_addr", word_t'(RW0_addr), word_t'(gw ? w_addr : r_addr));
    end
    if (gw) begin
      check_val("rw_wmask", word_t'(RW0_wmask), word_t'(w_mask));
      check_val("rw_wdata", RW0_wdata, w_data);
    end
    check_val("resp_valid", word_t'(resp_valid), word_t'(erv));
    if (erv) check_val("resp_data", resp_data, pend[0].data);
    last_rr = r_ready; last_wr = w_ready; last_rv = resp_valid;
    if (gr) pend.push_back('{shadow[r_addr], cyc});
    if (gw) begin
      m = expand_mask(w_mask);
      shadow[w_addr] = (shadow[w_addr] & ~m) | (w_data & m);
    end
    if (pop) void'(pend.pop_front());
    if (gr) wcnt = 0;
    else if (gw && r_valid && ok) wcnt = (wcnt < STARVE_MAX) ? wcnt + 1 : wcnt;
    else wcnt = 0;
    cyc++;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    w_valid = 1'b0; r_valid = 1'b0; reset_n = 1'b0;
    pend.delete(); wcnt = 0;
    @(negedge clock);
    check_val("rst_resp_valid", word_t'(resp_valid), word_t'(0));
    check_val("rst_resp_data", resp_data, '0);
    check_val("rst_rw_en", word_t'(RW0_en), word_t'(0));
    cyc++;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    w_valid = 1'b0; r_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cnt, issued;
    logic [9:0]  pat10;
    logic [11:0] rr12, rv12;

    do_reset();

    // Full write then immediate read of the same address
    w_valid = 1; w_addr = 9'h005; w_mask = 8'hFF; w_data = 80'h0123456789ABCDEF0011;
    step();
    w_valid = 0; r_valid = 1; r_addr = 9'h005; resp_ready = 1;
    step();
    r_valid = 0;
    step();
    check_val("t1_valid", word_t'(resp_valid), word_t'(1));
    check_val("t1_data", resp_data, 80'h0123456789ABCDEF0011);
    idle(2);

    // Single-lane write over zeros
    w_valid = 1; w_addr = 9'h1FF; w_mask = 8'h01; w_data = 80'h3FF;
    step();
    w_valid = 0; r_valid = 1; r_addr = 9'h1FF;
    step();
    r_valid = 0;
    step();
    check_val("t2_data", resp_data, 80'h3FF);
    idle(3);

    // Both channels held: four writes then a forced read
    w_valid = 1; r_valid = 1; r_addr = 9'h005; w_addr = 9'h020; w_mask = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      w_data = word_t'({$urandom(), $urandom(), $urandom()});
      step();
      pat10[i] = last_rr;
    end
    check_val("starve_pattern", word_t'(pat10), word_t'(10'h210));
    idle(4);

    // Response backpressure: only two reads may be outstanding
    resp_ready = 0; r_valid = 1; issued = 0; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      r_addr = ADDR_W'(9'h020 + issued);
      step();
      if (last_rr) issued++;
    end
    check_val("bp_grants", word_t'(issued), word_t'(2));
    w_valid = 1; w_addr = 9'h030; w_mask = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      w_data = word_t'({$urandom(), $urandom(), $urandom()});
      step();
      if (last_wr) cnt++;
    end
    check_val("bp_writes", word_t'(cnt), word_t'(3));
    w_valid = 0; resp_ready = 1;
    for (int i = 0; i < 20 && issued < 4; i++) begin
      r_addr = ADDR_W'(9'h020 + issued);
      step();
      if (last_rr) issued++;
    end
    check_val("bp_issued", word_t'(issued), word_t'(4));
    idle(4);

    // Streaming reads with a ready consumer
    for (int i = 0; i < 12; i++) begin
      r_valid = (i < 8); r_addr = ADDR_W'(i);
      step();
      rr12[i] = last_rr; rv12[i] = last_rv;
    end
    check_val("stream_rready", word_t'(rr12), word_t'(12'h0FF));
    check_val("stream_rvalid", word_t'(rv12), word_t'(12'h3FC));
    idle(2);

    // Reset while a read is in flight: its response must vanish
    r_valid = 1; r_addr = 9'h005; resp_ready = 0;
    step();
    do_reset();
    resp_ready = 0;
    step(); step(); step();
    check_val("post_rst_empty", word_t'(resp_valid), word_t'(0));
    r_valid = 1; r_addr = 9'h1FF; resp_ready = 1;
    step();
    r_valid = 0;
    step();
    check_val("post_rst_data", resp_data, 80'h3FF);
    idle(3);

    // Randomized traffic over a small address window to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      w_valid    = ($urandom_range(0, 99) < 50);
      r_valid    = ($urandom_range(0, 99) < 60);
      resp_ready = ($urandom_range(0, 99) < 60);
      w_addr     = ADDR_W'($urandom_range(0, 15));
      r_addr     = ADDR_W'($urandom_range(0, 15));
      w_mask     = ($urandom_range(0, 9) == 0) ? '0 : MASK_W'($urandom());
      w_data     = word_t'({$urandom(), $urandom(), $urandom()});
      step();
    end
    idle(6);
    check_val("final_drained", word_t'(pend.size()), word_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
